seg7_scan_display: RTL and testbench

//  Parametrised time-multiplexed 7-segment driver. Successor to the static per-bit display driver.

---
 rtl/seg7_scan_display_pkg.sv | 56 +++++
 rtl/seg7_scan_display_if.sv | 26 ++
 rtl/seg7_scan_display_glyph_enc.sv | 23 ++
 rtl/seg7_scan_display.sv | 114 +++++++++++
 tb/tb_seg7_scan_display.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_display_pkg.sv
// Shared glyph constants, display mode encoding and hex glyph lookup for the
// 7-segment display blocks. Segment order is {a,b,c,d,e,f,g}, active low.
package seg7_scan_display_pkg;

  typedef enum logic {
    MODE_BIN = 1'b0,
    MODE_HEX = 1'b1
  } mode_e;

  localparam logic [6:0] ZERO  = 7'b0000001;
  localparam logic [6:0] ONE   = 7'b1001111;
  localparam logic [6:0] BLANK = 7'b1111111;

  localparam logic [6:0] HEX_0 = 7'b0000001;
  localparam logic [6:0] HEX_1 = 7'b1001111;
  localparam logic [6:0] HEX_2 = 7'b0010010;
  localparam logic [6:0] HEX_3 = 7'b0000110;
  localparam logic [6:0] HEX_4 = 7'b1001100;
  localparam logic [6:0] HEX_5 = 7'b0100100;
  localparam logic [6:0] HEX_6 = 7'b0100000;
  localparam logic [6:0] HEX_7 = 7'b0001111;
  localparam logic [6:0] HEX_8 = 7'b0000000;
  localparam logic [6:0] HEX_9 = 7'b0000100;
  localparam logic [6:0] HEX_A = 7'b0001000;
  localparam logic [6:0] HEX_B = 7'b1100000;
  localparam logic [6:0] HEX_C = 7'b0110001;
  localparam logic [6:0] HEX_D = 7'b1000010;
  localparam logic [6:0] HEX_E = 7'b0110000;
  localparam logic [6:0] HEX_F = 7'b0111000;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
    logic [6:0] pattern;
    pattern = BLANK;
    case (nibble)
      4'h0: pattern = HEX_0;
      4'h1: pattern = HEX_1;
      4'h2: pattern = HEX_2;
      4'h3: pattern = HEX_3;
      4'h4: pattern = HEX_4;
      4'h5: pattern = HEX_5;
      4'h6: pattern = HEX_6;
      4'h7: pattern = HEX_7;
      4'h8: pattern = HEX_8;
      4'h9: pattern = HEX_9;
      4'hA: pattern = HEX_A;
      4'hB: pattern = HEX_B;
      4'hC: pattern = HEX_C;
      4'hD: pattern = HEX_D;
      4'hE: pattern = HEX_E;
      4'hF: pattern = HEX_F;
      default: pattern = BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Load handshake between the CPU result bus and the scanned display:
// the master offers a value and its mode, the display accepts when ready.
interface seg7_scan_display_if #(
  parameter int DATA_W = 16
) ();

  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;
  logic              load_hex;

  modport master (
    output load_valid,
    output load_data,
    output load_hex,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_hex,
    output load_ready
  );

endinterface

// File: rtl/seg7_scan_display_glyph_enc.sv
// Combinational glyph encoder: binary digits use nibble[0] only, hex digits
// use the full nibble, and blank overrides both.
module seg7_glyph_enc
  import seg7_scan_display_pkg::*;
(
  input  mode_e       mode,
  input  logic [3:0]  nibble,
  input  logic        blank,
  output logic [6:0]  pattern
);

  always_comb begin
    pattern = BLANK;
    if (!blank) begin
      if (mode == MODE_HEX) begin
        pattern = hex_glyph(nibble);
      end else begin
        pattern = nibble[0] ? ONE : ZERO;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 7-segment driver: scans NUM_DIGITS common-anode digits and
// swaps in newly loaded values only at frame boundaries so a frame never tears.
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int DATA_W      = 16,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  seg7_scan_display_if.slave    load,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_done
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [31:0] BIN_DIGITS = DATA_W;
  localparam logic [31:0] HEX_DIGITS = (DATA_W + 3) / 4;

  logic [DIV_W-1:0]  div_cnt;
  logic [IDX_W-1:0]  digit_idx;
  logic              tick;
  logic [DATA_W-1:0] pending_data;
  mode_e             pending_mode;
  logic              pending_full;
  logic [DATA_W-1:0] active_data;
  mode_e             active_mode;
  logic [63:0]       padded;
  logic [5:0]        bit_idx;
  logic [5:0]        nib_base;
  logic [3:0]        nibble;
  logic              blank;
  logic [6:0]        glyph;

  assign tick            = en && (div_cnt == DIV_LAST);
  assign frame_done      = tick && (digit_idx == IDX_LAST);
  assign load.load_ready = !pending_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      digit_idx <= '0;
    end else if (en) begin
      if (tick) begin
        div_cnt   <= '0;
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Commit needs pending_full already set, so a value accepted in the
  // frame-end cycle itself waits for the following frame end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_data <= '0;
      pending_mode <= MODE_BIN;
      pending_full <= 1'b0;
      active_data  <= '0;
      active_mode  <= MODE_BIN;
    end else if (frame_done && pending_full) begin
      active_data  <= pending_data;
      active_mode  <= pending_mode;
      pending_full <= 1'b0;
    end else if (load.load_valid && !pending_full) begin
      pending_data <= load.load_data;
      pending_mode <= mode_e'(load.load_hex);
      pending_full <= 1'b1;
    end
  end

  always_comb begin
    padded   = 64'(active_data);
    bit_idx  = 6'(digit_idx);
    nib_base = {bit_idx[3:0], 2'b00};
    nibble   = 4'h0;
    blank    = 1'b1;
    if (active_mode == MODE_HEX) begin
      nibble = padded[nib_base +: 4];
      blank  = (32'(digit_idx) >= HEX_DIGITS);
    end else begin
      nibble = {3'b000, padded[bit_idx]};
      blank  = (32'(digit_idx) >= BIN_DIGITS);
    end
  end

  seg7_glyph_enc u_glyph_enc (
    .mode    (active_mode),
    .nibble  (nibble),
    .blank   (blank),
    .pattern (glyph)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg <= BLANK;
      an  <= '1;
    end else if (en) begin
      seg <= glyph;
      an  <= ~(NUM_DIGITS'(1) << digit_idx);
    end else begin
      seg <= BLANK;
      an  <= '1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with 4 digits, 8-bit data and a
// 4-cycle digit slot; expected glyphs and timing are written out by hand.
module tb_seg7_scan_display;

  localparam logic [6:0] G_ZERO  = 7'b0000001;
  localparam logic [6:0] G_ONE   = 7'b1001111;
  localparam logic [6:0] G_BLANK = 7'b1111111;
  localparam logic [6:0] G_H1    = 7'b1001111;
  localparam logic [6:0] G_H2    = 7'b0010010;
  localparam logic [6:0] G_H3    = 7'b0000110;
  localparam logic [6:0] G_HC    = 7'b0110001;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_done;
  int         total_checks;
  int         bad_checks;

  seg7_scan_display_if #(.DATA_W(8)) lif ();

  seg7_scan_display #(
    .NUM_DIGITS  (4),
    .DATA_W      (8),
    .REFRESH_DIV (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (lif),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic hex);
    lif.load_data  = data;
    lif.load_hex   = hex;
    lif.load_valid = 1'b1;
  endtask

  task automatic waitFrameDone(output int cycles);
    cycles = 0;
    do begin
      stepCycle();
      cycles++;
    end while (frame_done !== 1'b1 && cycles < 40);
    checkOutput("frame_wait", 32'(frame_done), 32'd1);
  endtask

  // Starts and ends on a frame_done sample; the first edge still shows the
  // previous frame's last digit, so its segments are not checked.
  task automatic scanFrame(input string tag, input logic [6:0] d0, input logic [6:0] d1,
                           input logic [6:0] d2, input logic [6:0] d3);
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    int d;
    exp_seg = '{d0, d1, d2, d3};
    for (int j = 1; j <= 16; j++) begin
      stepCycle();
      if (j == 1) lif.load_valid = 1'b0;
      d = ((j + 14) / 4) % 4;
      exp_an = ~(4'b0001 << d);
      checkOutput({tag, "_an"}, 32'(an), 32'(exp_an));
      if (j >= 2) checkOutput({tag, "_seg"}, 32'(seg), 32'(exp_seg[d]));
      checkOutput({tag, "_fd"}, 32'(frame_done), (j == 16) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] res_an [6];
    logic [6:0] res_seg [6];
    int cycles;
    total_checks   = 0;
    bad_checks     = 0;
    rst_n          = 1'b0;
    en             = 1'b1;
    lif.load_valid = 1'b0;
    lif.load_data  = 8'h00;
    lif.load_hex   = 1'b0;

    repeat (3) stepCycle();
    checkOutput("rst_seg", 32'(seg), 32'h7F);
    checkOutput("rst_an", 32'(an), 32'hF);
    checkOutput("rst_ready", 32'(lif.load_ready), 32'd1);
    checkOutput("rst_fd", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("first_an", 32'(an), 32'hE);
    checkOutput("first_seg", 32'(seg), 32'(G_ZERO));

    applyStimulus(8'hA5, 1'b0);
    stepCycle();
    lif.load_valid = 1'b0;
    checkOutput("ready_pending", 32'(lif.load_ready), 32'd0);
    waitFrameDone(cycles);
    checkOutput("first_frame_len", 32'(cycles), 32'd13);
    scanFrame("bin_a5", G_ONE, G_ZERO, G_ONE, G_ZERO);
    checkOutput("ready_after_commit", 32'(lif.load_ready), 32'd1);

    stepCycle();
    applyStimulus(8'h3C, 1'b1);
    stepCycle();
    lif.load_valid = 1'b0;
    waitFrameDone(cycles);
    scanFrame("hex_3c", G_HC, G_H3, G_BLANK, G_BLANK);

    stepCycle();
    applyStimulus(8'h12, 1'b1);
    stepCycle();
    applyStimulus(8'hFF, 1'b1);
    checkOutput("ready_full", 32'(lif.load_ready), 32'd0);
    stepCycle();
    checkOutput("ready_full_hold", 32'(lif.load_ready), 32'd0);
    checkOutput("mid_frame_an", 32'(an), 32'hE);
    checkOutput("mid_frame_seg", 32'(seg), 32'(G_HC));
    stepCycle();
    lif.load_valid = 1'b0;
    waitFrameDone(cycles);
    scanFrame("hex_12", G_H2, G_H1, G_BLANK, G_BLANK);

    checkOutput("ready_at_frame_end", 32'(lif.load_ready), 32'd1);
    applyStimulus(8'hC6, 1'b0);
    scanFrame("keep_12", G_H2, G_H1, G_BLANK, G_BLANK);
    checkOutput("ready_collision", 32'(lif.load_ready), 32'd0);
    scanFrame("bin_c6", G_ZERO, G_ONE, G_ONE, G_ZERO);

    repeat (10) stepCycle();
    checkOutput("pre_freeze_an", 32'(an), 32'hB);
    checkOutput("pre_freeze_seg", 32'(seg), 32'(G_ONE));
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput("frozen_an", 32'(an), 32'hF);
      checkOutput("frozen_seg", 32'(seg), 32'h7F);
      checkOutput("frozen_fd", 32'(frame_done), 32'd0);
    end
    en = 1'b1;
    res_an  = '{4'hB, 4'hB, 4'hB, 4'h7, 4'h7, 4'h7};
    res_seg = '{G_ONE, G_ONE, G_ONE, G_ZERO, G_ZERO, G_ZERO};
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      checkOutput("resume_an", 32'(an), 32'(res_an[i]));
      checkOutput("resume_seg", 32'(seg), 32'(res_seg[i]));
      checkOutput("resume_fd", 32'(frame_done), (i == 5) ? 32'd1 : 32'd0);
    end

    repeat (3) stepCycle();
    applyStimulus(8'hFF, 1'b0);
    stepCycle();
    lif.load_valid = 1'b0;
    checkOutput("ready_before_rst", 32'(lif.load_ready), 32'd0);
    rst_n = 1'b0;
    repeat (2) stepCycle();
    checkOutput("midrst_seg", 32'(seg), 32'h7F);
    checkOutput("midrst_an", 32'(an), 32'hF);
    checkOutput("midrst_ready", 32'(lif.load_ready), 32'd1);
    checkOutput("midrst_fd", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("post_rst_an", 32'(an), 32'hE);
    checkOutput("post_rst_seg", 32'(seg), 32'(G_ZERO));
    waitFrameDone(cycles);
    checkOutput("post_rst_frame_len", 32'(cycles), 32'd14);
    scanFrame("post_rst", G_ZERO, G_ZERO, G_ZERO, G_ZERO);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
